// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the fetch/data memory arbiter
package mem_arb_pkg;
    typedef enum logic [1:0] {IDLE, DM_BUSY, IF_BUSY} state_t;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 32;
    localparam int WDOG_W = 4;
    localparam int WDOG_LIMIT = 15;
endpackage

// File: rtl/mem_arb_wdog.sv
// mem_arb_wdog: busy-cycle watchdog; expire when the count reaches WDOG_LIMIT while enabled
// Ports: clk_i/rst_i clock and sync reset; en counts a stalled busy cycle; clr zeroes the count;
// expire flags the cycle in which the limit is reached.
module mem_arb_wdog
    import mem_arb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic en,
    input  logic clr,
    output logic expire
);
    logic [WDOG_W-1:0] cnt;
    assign expire = en & (cnt == WDOG_W'(WDOG_LIMIT));
    always_ff @(posedge clk_i) begin
        if (rst_i || clr) cnt <= '0;
        else if (en && !expire) cnt <= cnt + 1'b1;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port (fetch/data) arbiter onto one unified memory port with anti-starvation
// Ports: clk_i/rst_i clock and sync active-high reset; if_* fetch requester; dm_* data requester;
// mem_* unified memory master; stall_o pipeline freeze; err_o watchdog timeout pulse.
// Build option: define MEM_ARB_TIMEOUT_EN to add the busy watchdog; otherwise err_o is tied low.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_ack_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_ack_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i,
    output logic              stall_o,
    output logic              err_o
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    state_t state, state_n;
    logic [SW-1:0] starve_cnt;
    logic [ADDR_W-1:0] cap_addr;
    logic [DATA_W-1:0] cap_wdata;
    logic cap_we, busy, dm_elig, if_elig, force_if, grant_dm, grant_if, expire, done;

    assign busy = state != IDLE;
    // a requester whose ack is showing is the one being retired, so it cannot win again this cycle
    assign dm_elig = dm_req_i & ~dm_ack_o;
    assign if_elig = if_req_i & ~if_ack_o;
    assign force_if = dm_elig & if_elig & (starve_cnt == SW'(STARVE_LIMIT));
    assign grant_dm = (state == IDLE) & dm_elig & ~force_if;
    assign grant_if = (state == IDLE) & if_elig & (~dm_elig | force_if);
    assign done = busy & (mem_ack_i | expire);

    assign mem_req_o = busy;
    assign mem_we_o = busy & cap_we;
    assign mem_addr_o = cap_addr;
    assign mem_wdata_o = cap_wdata;
    assign stall_o = (if_req_i & ~if_ack_o) | (dm_req_i & ~dm_ack_o);

`ifdef MEM_ARB_TIMEOUT_EN
    mem_arb_wdog u_wdog (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .en    (busy & ~mem_ack_i),
        .clr   (~busy),
        .expire(expire)
    );
    always_ff @(posedge clk_i) err_o <= ~rst_i & expire;
`else
    assign expire = 1'b0;
    assign err_o = 1'b0;
`endif

    always_comb begin
        state_n = grant_dm ? DM_BUSY : grant_if ? IF_BUSY : done ? IDLE : state;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state <= IDLE;
        else state <= state_n;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            starve_cnt <= '0;
            cap_addr <= '0;
            cap_we <= 1'b0;
            cap_wdata <= '0;
            if_ack_o <= 1'b0;
            dm_ack_o <= 1'b0;
            if_rdata_o <= '0;
            dm_rdata_o <= '0;
        end else begin
            if_ack_o <= done & (state == IF_BUSY);
            dm_ack_o <= done & (state == DM_BUSY);
            if (grant_if) starve_cnt <= '0;
            else if (grant_dm && if_req_i && starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
            if (grant_dm) begin
                cap_addr <= dm_addr_i;
                cap_we <= dm_we_i;
                cap_wdata <= dm_wdata_i;
            end else if (grant_if) begin
                cap_addr <= if_addr_i;
                cap_we <= 1'b0;
                cap_wdata <= '0;
            end
            // a watchdog expiry returns zero data rather than whatever the bus holds
            if (done && state == DM_BUSY) dm_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
            if (done && state == IF_BUSY) if_rdata_o <= mem_ack_i ? mem_rdata_i : '0;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter
module tb_mem_arbiter;
    logic clk = 1'b0;
    logic rst_i = 1'b1;
    logic if_req_i = 1'b0, dm_req_i = 1'b0, dm_we_i = 1'b0, mem_ack_i = 1'b0;
    logic [31:0] if_addr_i = '0, dm_addr_i = '0, dm_wdata_i = '0, mem_rdata_i = '0;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic if_ack_o, dm_ack_o, mem_req_o, mem_we_o, stall_o, err_o;
    logic mem_en = 1'b1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_i),
        .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_rdata_o(if_rdata_o), .if_ack_o(if_ack_o),
        .dm_req_i(dm_req_i), .dm_we_i(dm_we_i), .dm_addr_i(dm_addr_i), .dm_wdata_i(dm_wdata_i),
        .dm_rdata_o(dm_rdata_o), .dm_ack_o(dm_ack_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
        .mem_rdata_i(mem_rdata_i), .mem_ack_i(mem_ack_i),
        .stall_o(stall_o), .err_o(err_o)
    );

    // memory model: acks on the second cycle a request is visible; data 0xDEADBEEF at 0x10, else ~addr
    initial begin
        int cnt;
        cnt = 0;
        forever begin
            @(negedge clk);
            if (mem_en) begin
                if (mem_req_o && !mem_ack_i) begin
                    cnt++;
                    if (cnt == 2) begin
                        mem_ack_i = 1'b1;
                        mem_rdata_i = (mem_addr_o == 32'h10) ? 32'hDEADBEEF : ~mem_addr_o;
                        cnt = 0;
                    end
                end else begin
                    mem_ack_i = 1'b0;
                    if (!mem_req_o) cnt = 0;
                end
            end
        end
    end

    task automatic apply_reset();
        @(negedge clk);
        rst_i = 1'b1;
        if_req_i = 1'b0;
        dm_req_i = 1'b0;
        dm_we_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL reset_mem_req got=%b exp=0", mem_req_o); end
        checks++; if ({if_ack_o, dm_ack_o, err_o} !== 3'b000) begin errors++; $display("FAIL reset_acks got=%b exp=000", {if_ack_o, dm_ack_o, err_o}); end
        checks++; if (if_rdata_o !== 32'h0 || dm_rdata_o !== 32'h0) begin errors++; $display("FAIL reset_rdata got=%h/%h exp=0/0", if_rdata_o, dm_rdata_o); end
        checks++; if (mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0 || mem_we_o !== 1'b0) begin errors++; $display("FAIL reset_fields got=%h/%h/%b exp=0", mem_addr_o, mem_wdata_o, mem_we_o); end
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
    endtask

    task automatic test_fetch();
        int at, stall_bad;
        logic [31:0] rd;
        logic st;
        at = -1; stall_bad = 0; rd = '0; st = 1'b1;
        @(negedge clk);
        if_req_i = 1'b1;
        if_addr_i = 32'h10;
        #1;
        checks++; if (stall_o !== 1'b1) begin errors++; $display("FAIL fetch_stall_comb got=%b exp=1", stall_o); end
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h10}) begin errors++; $display("FAIL fetch_bus got=%b%b %h exp=10 00000010", mem_req_o, mem_we_o, mem_addr_o); end
            end
            if (if_ack_o) begin
                at = i; rd = if_rdata_o; st = stall_o;
                if_req_i = 1'b0;
                break;
            end else if (!stall_o) stall_bad++;
        end
        checks++; if (at !== 3) begin errors++; $display("FAIL fetch_latency got=%0d exp=3", at); end
        checks++; if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata got=%h exp=deadbeef", rd); end
        checks++; if (st !== 1'b0 || stall_bad !== 0) begin errors++; $display("FAIL fetch_stall got=%b/%0d exp=0/0", st, stall_bad); end
        @(negedge clk);
        checks++; if (if_ack_o !== 1'b0 || if_rdata_o !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_ack_pulse_hold got=%b %h exp=0 deadbeef", if_ack_o, if_rdata_o); end
    endtask

    task automatic test_dual();
        int dm_cnt, if_cnt, dm_at, if_at;
        dm_cnt = 0; if_cnt = 0; dm_at = -1; if_at = -1;
        @(negedge clk);
        dm_req_i = 1'b1; dm_we_i = 1'b1; dm_addr_i = 32'h80; dm_wdata_i = 32'h5;
        if_req_i = 1'b1; if_addr_i = 32'h20;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (i == 1) begin
                checks++; if ({mem_we_o, mem_addr_o, mem_wdata_o} !== {1'b1, 32'h80, 32'h5}) begin errors++; $display("FAIL dual_dm_bus got=%b %h %h exp=1 00000080 00000005", mem_we_o, mem_addr_o, mem_wdata_o); end
            end
            if (i == 4) begin
                checks++; if ({mem_req_o, mem_we_o, mem_addr_o} !== {2'b10, 32'h20}) begin errors++; $display("FAIL dual_if_bus got=%b%b %h exp=10 00000020", mem_req_o, mem_we_o, mem_addr_o); end
            end
            if (dm_ack_o) begin dm_cnt++; dm_at = i; dm_req_i = 1'b0; dm_we_i = 1'b0; end
            if (if_ack_o) begin if_cnt++; if_at = i; if_req_i = 1'b0; end
        end
        checks++; if (dm_cnt !== 1 || dm_at !== 3) begin errors++; $display("FAIL dual_dm_ack got=%0d@%0d exp=1@3", dm_cnt, dm_at); end
        checks++; if (if_cnt !== 1 || if_at !== 6) begin errors++; $display("FAIL dual_if_ack got=%0d@%0d exp=1@6", if_cnt, if_at); end
        checks++; if (dm_rdata_o !== 32'hFFFFFF7F || if_rdata_o !== 32'hFFFFFFDF) begin errors++; $display("FAIL dual_rdata got=%h/%h exp=ffffff7f/ffffffdf", dm_rdata_o, if_rdata_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] g_addr [3];
        int g_at [3];
        int n;
        logic prev;
        n = 0; prev = 1'b0;
        apply_reset();
        dm_req_i = 1'b1; dm_addr_i = 32'h100;
        if_req_i = 1'b1; if_addr_i = 32'h200;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            if (mem_req_o && !prev && n < 3) begin g_addr[n] = mem_addr_o; g_at[n] = i; n++; end
            prev = mem_req_o;
        end
        checks++; if (n !== 3) begin errors++; $display("FAIL b2b_grants got=%0d exp=3", n); end
        else begin
            checks++; if ({g_addr[0], g_addr[1], g_addr[2]} !== {32'h100, 32'h200, 32'h100}) begin errors++; $display("FAIL b2b_order got=%h %h %h exp=100 200 100", g_addr[0], g_addr[1], g_addr[2]); end
            checks++; if (g_at[0] !== 1 || g_at[1] !== 4 || g_at[2] !== 7) begin errors++; $display("FAIL b2b_timing got=%0d %0d %0d exp=1 4 7", g_at[0], g_at[1], g_at[2]); end
        end
        apply_reset();
    endtask

    task automatic test_starve();
        logic [31:0] g_addr [5];
        int g_at [5];
        int n;
        logic prev;
        n = 0; prev = 1'b0;
        apply_reset();
        dm_req_i = 1'b1; dm_addr_i = 32'h100;
        if_req_i = 1'b1; if_addr_i = 32'h200;
        for (int i = 1; i <= 40 && n < 5; i++) begin
            @(negedge clk);
            if (mem_req_o && !prev) begin g_addr[n] = mem_addr_o; g_at[n] = i; n++; end
            prev = mem_req_o;
            if_req_i = ~dm_ack_o;
        end
        checks++; if (n !== 5) begin errors++; $display("FAIL starve_grants got=%0d exp=5", n); end
        else begin
            checks++; if ({g_addr[0], g_addr[1], g_addr[2], g_addr[3]} !== {4{32'h100}}) begin errors++; $display("FAIL starve_dm_first4 got=%h %h %h %h exp=100 x4", g_addr[0], g_addr[1], g_addr[2], g_addr[3]); end
            checks++; if (g_addr[4] !== 32'h200 || g_at[4] !== 17) begin errors++; $display("FAIL starve_if_fifth got=%h@%0d exp=200@17", g_addr[4], g_at[4]); end
        end
        apply_reset();
    endtask

    task automatic test_drop();
        int cnt, at;
        cnt = 0; at = -1;
        @(negedge clk);
        dm_req_i = 1'b1; dm_we_i = 1'b0; dm_addr_i = 32'h40;
        for (int i = 1; i <= 6; i++) begin
            @(negedge clk);
            if (i == 1) dm_req_i = 1'b0;
            if (dm_ack_o) begin cnt++; at = i; end
        end
        checks++; if (cnt !== 1 || at !== 3) begin errors++; $display("FAIL drop_ack got=%0d@%0d exp=1@3", cnt, at); end
        checks++; if (dm_rdata_o !== 32'hFFFFFFBF) begin errors++; $display("FAIL drop_rdata got=%h exp=ffffffbf", dm_rdata_o); end
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        int at, err_cnt;
        logic e;
        logic [31:0] rd;
        at = -1; err_cnt = 0; e = 1'b0; rd = 32'h1;
        @(negedge clk);
        mem_en = 1'b0;
        mem_ack_i = 1'b0;
        dm_req_i = 1'b1; dm_addr_i = 32'h44;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) dm_req_i = 1'b0;
            if (err_o) err_cnt++;
            if (dm_ack_o && at < 0) begin at = i; e = err_o; rd = dm_rdata_o; end
        end
        checks++; if (at !== 17 || e !== 1'b1) begin errors++; $display("FAIL timeout_ack got=%0d err=%b exp=17 err=1", at, e); end
        checks++; if (rd !== 32'h0 || err_cnt !== 1) begin errors++; $display("FAIL timeout_rdata got=%h pulses=%0d exp=0 pulses=1", rd, err_cnt); end
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL timeout_idle got=%b exp=0", mem_req_o); end
        mem_en = 1'b1;
    endtask
`endif

    task automatic test_reset_busy();
        int bad;
        bad = 0;
        apply_reset();
        mem_en = 1'b0;
        mem_ack_i = 1'b0;
        @(negedge clk);
        if_req_i = 1'b1; if_addr_i = 32'h30;
        @(negedge clk);
        checks++; if (mem_req_o !== 1'b1) begin errors++; $display("FAIL rstbusy_granted got=%b exp=1", mem_req_o); end
        rst_i = 1'b1;
        if_req_i = 1'b0;
        @(negedge clk);
        rst_i = 1'b0;
        checks++; if (mem_req_o !== 1'b0) begin errors++; $display("FAIL rstbusy_mem_req got=%b exp=0", mem_req_o); end
        for (int i = 1; i <= 6; i++) begin
            mem_ack_i = (i == 1);
            @(negedge clk);
            if (if_ack_o || dm_ack_o || mem_req_o || err_o) bad++;
        end
        mem_ack_i = 1'b0;
        checks++; if (bad !== 0) begin errors++; $display("FAIL rstbusy_quiet got=%0d exp=0", bad); end
        mem_en = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_dual();
        test_back_to_back();
        test_starve();
        test_drop();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_busy();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
